// File: rtl/bvh_traversal_ctrl.sv
// bvh_traversal_ctrl: depth-first BVH walker feeding a combinational ray/box unit,
// emitting hit leaves and narrowing the ray's far distance from reported primitive hits.
module bvh_traversal_ctrl #(
    parameter int NODE_AW     = 10,
    parameter int STACK_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ray_valid,
    output logic                      ray_ready,
    input  logic [71:0]               ray_orig,
    input  logic [71:0]               inv_ray_dir,
    input  logic [47:0]               t_range,
    output logic                      node_rd_en,
    output logic [NODE_AW-1:0]        node_addr,
    input  logic [NODE_AW+148:0]      node_rd_data,
    output logic [71:0]               isect_orig,
    output logic [71:0]               isect_inv_dir,
    output logic [143:0]              isect_box,
    output logic [47:0]               isect_range,
    input  logic                      isect_hit,
    input  logic [47:0]               isect_range_in,
    output logic                      leaf_valid,
    input  logic                      leaf_ready,
    output logic [NODE_AW-1:0]        leaf_prim_base,
    output logic [3:0]                leaf_prim_cnt,
    output logic [47:0]               leaf_range,
    input  logic                      hit_t_valid,
    input  logic [23:0]               hit_t,
    output logic                      done,
    output logic                      overflow
);
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = $clog2(STACK_DEPTH);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, TEST, EMIT, DONE} state_t;

    state_t state, state_nx;
    logic [NODE_AW-1:0] stack [STACK_DEPTH];
    logic [SPW-1:0] sp, top, free;
    logic [IW-1:0] top_i, sp_i, sp1_i;
    logic empty, push, is_leaf;
    logic [NODE_AW-1:0] child;
    logic [3:0] cnt;

    assign empty = sp == '0;
    assign top   = sp - SPW'(1);
    assign free  = SPW'(STACK_DEPTH) - sp;
    assign top_i = top[IW-1:0];
    assign sp_i  = sp[IW-1:0];
    assign sp1_i = IW'(sp + SPW'(1));
    assign push  = state == TEST && isect_hit && !is_leaf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        ray_ready  = state == IDLE;
        node_rd_en = state == FETCH && !empty;
        node_addr  = node_rd_en ? stack[top_i] : '0;
        leaf_valid = state == EMIT;
        done       = state == DONE;
        case (state)
            IDLE:    state_nx = ray_valid ? FETCH : IDLE;
            FETCH:   state_nx = empty ? DONE : LOAD;
            LOAD:    state_nx = TEST;
            TEST:    state_nx = (isect_hit && is_leaf) ? EMIT : FETCH;
            EMIT:    state_nx = leaf_ready ? FETCH : EMIT;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Stack storage needs no reset: sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (state == IDLE && ray_valid) stack[0] <= '0;
        else if (push && free >= SPW'(2)) begin
            stack[sp_i]  <= child + 1'b1;
            stack[sp1_i] <= child;
        end else if (push && free == SPW'(1)) stack[sp_i] <= child;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp             <= '0;
            overflow       <= 1'b0;
            isect_orig     <= '0;
            isect_inv_dir  <= '0;
            isect_box      <= '0;
            isect_range    <= '0;
            is_leaf        <= 1'b0;
            child          <= '0;
            cnt            <= '0;
            leaf_prim_base <= '0;
            leaf_prim_cnt  <= '0;
            leaf_range     <= '0;
        end else begin
            if (state == IDLE && ray_valid) begin
                isect_orig    <= ray_orig;
                isect_inv_dir <= inv_ray_dir;
                isect_range   <= t_range;
                sp            <= SPW'(1);
                overflow      <= 1'b0;
            end
            if (node_rd_en) sp <= top;
            if (state == LOAD) begin
                isect_box <= node_rd_data[NODE_AW+148 -: 144];
                is_leaf   <= node_rd_data[NODE_AW+4];
                child     <= node_rd_data[NODE_AW+3 -: NODE_AW];
                cnt       <= node_rd_data[3:0];
            end
            if (state == TEST && isect_hit && is_leaf) begin
                leaf_prim_base <= child;
                leaf_prim_cnt  <= cnt;
                leaf_range     <= isect_range_in;
            end
            // Left child wins the last free slot; the dropped right subtree is flagged.
            if (push) begin
                sp <= sp + (free >= SPW'(2) ? SPW'(2) : free);
                if (free < SPW'(2)) overflow <= 1'b1;
            end
            if (hit_t_valid && state != IDLE && hit_t < isect_range[23:0]) isect_range[23:0] <= hit_t;
        end
    end
endmodule

// File: tb/tb_bvh_traversal_ctrl.sv
// tb_bvh_traversal_ctrl: directed trees against a +x-only slab model of the intersection unit.
module tb_bvh_traversal_ctrl;
    logic clk = 0, rst, ray_valid, ray_ready, node_rd_en, isect_hit, leaf_valid, leaf_ready;
    logic hit_t_valid, done, overflow;
    logic [71:0] ray_orig, inv_ray_dir, isect_orig, isect_inv_dir;
    logic [47:0] t_range, isect_range, isect_range_in, leaf_range;
    logic [9:0] node_addr, leaf_prim_base;
    logic [158:0] node_rd_data;
    logic [143:0] isect_box;
    logic [3:0] leaf_prim_cnt;
    logic [23:0] hit_t;
    logic [158:0] mem [0:1023];
    int n_chk = 0, n_err = 0, cyc = 0, t_acc = 0, t_done = 0, n_done = 0, lat, bad, nd0;
    int reads[$], lb[$], lc[$];
    logic [47:0] lr[$];

    localparam logic [71:0] HIT  = {24'hffffff, 24'd5, 24'd5};
    localparam logic [71:0] MISS = {24'hffffff, 24'd20, 24'd5};

    always #5 clk = ~clk;

    bvh_traversal_ctrl u_dut (
        .clk(clk), .rst(rst), .ray_valid(ray_valid), .ray_ready(ray_ready),
        .ray_orig(ray_orig), .inv_ray_dir(inv_ray_dir), .t_range(t_range),
        .node_rd_en(node_rd_en), .node_addr(node_addr), .node_rd_data(node_rd_data),
        .isect_orig(isect_orig), .isect_inv_dir(isect_inv_dir), .isect_box(isect_box),
        .isect_range(isect_range), .isect_hit(isect_hit), .isect_range_in(isect_range_in),
        .leaf_valid(leaf_valid), .leaf_ready(leaf_ready), .leaf_prim_base(leaf_prim_base),
        .leaf_prim_cnt(leaf_prim_cnt), .leaf_range(leaf_range), .hit_t_valid(hit_t_valid),
        .hit_t(hit_t), .done(done), .overflow(overflow)
    );

    always @(posedge clk) if (node_rd_en) node_rd_data <= mem[node_addr];

    // Slab test valid only for rays travelling along +x with unit inverse direction.
    logic signed [23:0] ox, oy, oz, x0, y0, z0, x1, y1, z1, rx, ry, te, tx;
    always_comb begin
        {ox, oy, oz} = isect_orig;
        {x0, y0, z0, x1, y1, z1} = isect_box;
        {rx, ry} = isect_range;
        te = (x0 - ox > rx) ? x0 - ox : rx;
        tx = (x1 - ox < ry) ? x1 - ox : ry;
        isect_hit = oy >= y0 && oy <= y1 && oz >= z0 && oz <= z1 && te <= tx;
        isect_range_in = {te, tx};
    end

    always @(negedge clk) begin
        cyc++;
        if (ray_valid && ray_ready) begin
            t_acc = cyc;
            reads.delete(); lb.delete(); lc.delete(); lr.delete();
        end
        if (node_rd_en) reads.push_back(int'(node_addr));
        if (leaf_valid && leaf_ready) begin
            lb.push_back(int'(leaf_prim_base));
            lc.push_back(int'(leaf_prim_cnt));
            lr.push_back(leaf_range);
        end
        if (done) begin
            n_done++;
            t_done = cyc;
        end
    end

    function automatic logic [158:0] mk(input int ax, ay, az, bx, by, bz, input bit leaf, input int ch, cn);
        return {24'(ax), 24'(ay), 24'(az), 24'(bx), 24'(by), 24'(bz), leaf, 10'(ch), 4'(cn)};
    endfunction

    function automatic logic [63:0] pack_q(input int q[$]);
        logic [63:0] r = 64'(q.size());
        foreach (q[i]) r = (r << 8) | 64'(q[i] & 255);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_ray(input logic [71:0] o);
        ray_orig = o;
        ray_valid = 1;
        @(posedge clk); #1;
        ray_valid = 0;
    endtask

    task automatic wait_done(input int budget, output int l);
        bit got = 0;
        l = -1;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            got = done;
        end
        @(posedge clk); #1;
        if (!got) check("done_timeout", 0, 1);
        else l = t_done - t_acc;
    endtask

    task automatic wait_leaf(input int budget);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            got = leaf_valid;
        end
        if (!got) check("leaf_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1; ray_valid = 0; leaf_ready = 1; hit_t_valid = 0; hit_t = 0;
        ray_orig = 0; inv_ray_dir = {24'd1, 24'd0, 24'd0}; t_range = {24'd0, 24'd1000};
        mem[0] = mk(0, 0, 0, 10, 10, 10, 1, 5, 3);
        repeat (3) @(posedge clk); #1;
        check("rst_ray_ready", ray_ready, 1);
        check("rst_leaf_valid", leaf_valid, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_rd_en", node_rd_en, 0);
        check("rst_addr", node_addr, 0);
        check("rst_range", isect_range, 0);
        check("rst_box", isect_box[63:0], 0);
        check("rst_leaf_base", leaf_prim_base, 0);
        rst = 0;
        @(posedge clk); #1;
        // Single-leaf root, hit and miss.
        send_ray(HIT);
        check("t1_isect_orig", isect_orig[63:0], HIT[63:0]);
        wait_done(50, lat);
        check("t1_latency", lat, 6);
        check("t1_leaves", pack_q(lb), 64'h105);
        check("t1_cnt", pack_q(lc), 64'h103);
        check("t1_range", lr.size() > 0 ? lr[0] : 48'h0, {24'd1, 24'd11});
        check("t1_overflow", overflow, 0);
        send_ray(MISS);
        wait_done(50, lat);
        check("t2_latency", lat, 5);
        check("t2_leaves", lb.size(), 0);
        // Root with two hit leaf children; second has prim count 0.
        mem[0] = mk(0, 0, 0, 20, 20, 20, 0, 1, 0);
        mem[1] = mk(1, 0, 0, 5, 10, 10, 1, 10, 1);
        mem[2] = mk(7, 0, 0, 12, 10, 10, 1, 20, 0);
        send_ray(HIT);
        wait_done(100, lat);
        check("t3_latency", lat, 13);
        check("t3_reads", pack_q(reads), 64'h3000102);
        check("t3_leaves", pack_q(lb), 64'h20a14);
        check("t3_cnt", pack_q(lc), 64'h20100);
        check("t3_range1", lr.size() > 1 ? lr[1] : 48'h0, {24'd8, 24'd13});
        // Closer primitive hit culls the far leaf.
        send_ray(HIT);
        wait_leaf(50);
        @(posedge clk); #1;
        hit_t_valid = 1; hit_t = 3;
        @(posedge clk); #1;
        hit_t_valid = 0;
        wait_done(100, lat);
        check("t6_latency", lat, 12);
        check("t6_leaves", pack_q(lb), 64'h10a);
        check("t6_range_y", isect_range[23:0], 3);
        // Three-level tree with a stalled downstream.
        mem[1] = mk(0, 0, 0, 20, 20, 20, 0, 3, 0);
        mem[2] = mk(7, 0, 0, 12, 10, 10, 1, 50, 6);
        mem[3] = mk(1, 0, 0, 5, 10, 10, 1, 30, 4);
        mem[4] = mk(2, 0, 0, 6, 10, 10, 1, 40, 5);
        leaf_ready = 0;
        send_ray(HIT);
        wait_leaf(50);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!leaf_valid || leaf_prim_base != 30 || leaf_prim_cnt != 4 ||
                leaf_range != {24'd2, 24'd6} || node_rd_en) bad++;
        end
        check("t4_stall_hold", bad, 0);
        @(posedge clk); #1;
        leaf_ready = 1;
        wait_done(100, lat);
        check("t4_reads", pack_q(reads), 64'h50001030402);
        check("t4_leaves", pack_q(lb), 64'h31e2832);
        // Left-deep chain of 20 internal levels overflows the 16-entry stack.
        mem[0] = mk(0, 0, 0, 20, 20, 20, 0, 1, 0);
        for (int l = 1; l < 20; l++) mem[2*l-1] = mk(0, 0, 0, 20, 20, 20, 0, 2*l+1, 0);
        for (int l = 0; l < 20; l++) mem[2*l+2] = mk(0, 100, 0, 20, 110, 20, 1, 99, 9);
        mem[39] = mk(1, 0, 0, 5, 10, 10, 1, 7, 2);
        send_ray(HIT);
        wait_done(600, lat);
        check("t5_overflow", overflow, 1);
        check("t5_leaves", pack_q(lb), 64'h107);
        check("t5_reads", reads.size(), 36);
        // Overflow clears on the next accept.
        mem[0] = mk(0, 0, 0, 10, 10, 10, 1, 5, 3);
        send_ray(HIT);
        check("t8_overflow_clr", overflow, 0);
        wait_done(50, lat);
        check("t8_leaves", pack_q(lb), 64'h105);
        // Reset during EMIT drops the ray without a done pulse.
        leaf_ready = 0;
        send_ray(HIT);
        wait_leaf(50);
        nd0 = n_done;
        rst = 1;
        #1;
        check("t7_leaf_valid", leaf_valid, 0);
        check("t7_ray_ready", ray_ready, 1);
        @(posedge clk); #1;
        rst = 0;
        leaf_ready = 1;
        repeat (10) @(posedge clk);
        #1;
        check("t7_no_done", n_done - nd0, 0);
        check("t7_idle", ray_ready, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
